// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between requester A
// (ALU result) and requester B (memory load). Each requester has a one-entry
// buffer. One buffered write is granted per cycle and presented as a
// registered write/write_address/write_data triple. The register file commits
// on the falling edge.
// Optional macro REG_ARB_FIXED_PRIO_EN: A always wins when both buffers are
// full. Otherwise the two requesters alternate.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              write,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] hz_addr,
  output logic              hz_pending,
  output logic [DATA_W-1:0] hz_data
);

  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
`ifndef REG_ARB_FIXED_PRIO_EN
  logic              last_grant_b_q, last_grant_b_d;
`endif

  logic gnt_a, gnt_b;
  logic a_acc, b_acc;
  logic a_hit, b_hit, w_hit, hz_nz;

  // Grant selection from the buffer full flags.
  always_comb begin
`ifdef REG_ARB_FIXED_PRIO_EN
    gnt_a = a_full_q;
`else
    gnt_a = a_full_q && (!b_full_q || last_grant_b_q);
`endif
    gnt_b = b_full_q && !gnt_a;
  end

  // A buffer that is being drained this cycle can refill on the same edge.
  assign a_ready = !a_full_q || gnt_a;
  assign b_ready = !b_full_q || gnt_b;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;

  // Buffer refill/drain and issue of the granted entry to the write port.
  always_comb begin
    a_full_d        = a_acc || (a_full_q && !gnt_a);
    a_addr_d        = a_acc ? a_addr : a_addr_q;
    a_data_d        = a_acc ? a_data : a_data_q;
    b_full_d        = b_acc || (b_full_q && !gnt_b);
    b_addr_d        = b_acc ? b_addr : b_addr_q;
    b_data_d        = b_acc ? b_data : b_data_q;
    write_d         = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
`ifndef REG_ARB_FIXED_PRIO_EN
    last_grant_b_d  = last_grant_b_q;
`endif
    if (gnt_a) begin
      // Register 0 is hard-wired: drained and rotated, but never written.
      write_d         = (a_addr_q != '0);
      write_address_d = a_addr_q;
      write_data_d    = a_data_q;
`ifndef REG_ARB_FIXED_PRIO_EN
      last_grant_b_d  = 1'b0;
`endif
    end else if (gnt_b) begin
      write_d         = (b_addr_q != '0);
      write_address_d = b_addr_q;
      write_data_d    = b_data_q;
`ifndef REG_ARB_FIXED_PRIO_EN
      last_grant_b_d  = 1'b1;
`endif
    end
  end

  // State registers; reset discards buffered entries and drops write at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_full_q        <= 1'b0;
      a_addr_q        <= '0;
      a_data_q        <= '0;
      b_full_q        <= 1'b0;
      b_addr_q        <= '0;
      b_data_q        <= '0;
      write_q         <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
      last_grant_b_q  <= 1'b1;
`endif
    end else begin
      a_full_q        <= a_full_d;
      a_addr_q        <= a_addr_d;
      a_data_q        <= a_data_d;
      b_full_q        <= b_full_d;
      b_addr_q        <= b_addr_d;
      b_data_q        <= b_data_d;
      write_q         <= write_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
`ifndef REG_ARB_FIXED_PRIO_EN
      last_grant_b_q  <= last_grant_b_d;
`endif
    end
  end

  assign write         = write_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;

  // Hazard lookup: buffers are younger than the write port; with both
  // buffers matching, the one that will be granted later holds the newer data.
  always_comb begin
    hz_nz      = (hz_addr != '0);
    a_hit      = a_full_q && (a_addr_q == hz_addr);
    b_hit      = b_full_q && (b_addr_q == hz_addr);
    w_hit      = write_q && (write_address_q == hz_addr);
    hz_pending = hz_nz && (a_hit || b_hit || w_hit);
    hz_data    = '0;
    if (hz_nz) begin
      if (a_hit && b_hit) hz_data = gnt_a ? b_data_q : a_data_q;
      else if (a_hit)     hz_data = a_data_q;
      else if (b_hit)     hz_data = b_data_q;
      else if (w_hit)     hz_data = write_data_q;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed cases followed by
// random traffic, checked against a transaction-level model built from
// per-requester queues and a register-file image.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, hz_addr;
  logic [31:0] a_data, b_data;
  logic        write;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        hz_pending;
  logic [31:0] hz_data;

  int ncmp  = 0;
  int nfail = 0;

  reg_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write(write), .write_address(write_address), .write_data(write_data),
    .hz_addr(hz_addr), .hz_pending(hz_pending), .hz_data(hz_data)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT, committing on the falling edge.
  logic [31:0] rf [32];
  always @(negedge clk) if (write === 1'b1) rf[write_address] <= write_data;

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
  ent_t        qa[$];
  ent_t        qb[$];
  bit          m_last_b;
  bit          m_w;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] mregs [32];
  bit          acc_a, acc_b;

  // 0 = none, 1 = A, 2 = B
  function automatic int m_gnt();
    if (qa.size() != 0 && qb.size() != 0) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      return 1;
`else
      return m_last_b ? 1 : 2;
`endif
    end
    if (qa.size() != 0) return 1;
    if (qb.size() != 0) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_last_b = 1'b1;
    m_w = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic model_edge();
    int g;
    ent_t e;
    g = m_gnt();
    acc_a = a_valid && (qa.size() == 0 || g == 1);
    acc_b = b_valid && (qb.size() == 0 || g == 2);
    m_w = 1'b0;
    if (g == 1) begin
      e = qa.pop_front();
    end else if (g == 2) begin
      e = qb.pop_front();
    end
    if (g != 0) begin
      m_w = (e.addr != 0);
      m_wa = e.addr;
      m_wd = e.data;
      m_last_b = (g == 2);
    end
    if (acc_a) qa.push_back('{a_addr, a_data});
    if (acc_b) qb.push_back('{b_addr, b_data});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    int g, k;
    bit ha, hb, hw, pend;
    logic [31:0] d;
    g = m_gnt();
    chk("a_ready", a_ready, (qa.size() == 0 || g == 1));
    chk("b_ready", b_ready, (qb.size() == 0 || g == 2));
    ha = qa.size() != 0 && qa[0].addr == hz_addr;
    hb = qb.size() != 0 && qb[0].addr == hz_addr;
    hw = m_w && m_wa == hz_addr;
    pend = hz_addr != 0 && (ha || hb || hw);
    d = 0;
    if (pend) begin
      if (ha && hb) d = (g == 1) ? qb[0].data : qa[0].data;
      else if (ha)  d = qa[0].data;
      else if (hb)  d = qb[0].data;
      else          d = m_wd;
    end
    chk("hz_pending", hz_pending, pend);
    chk("hz_data", hz_data, d);
    k = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== mregs[i]) k = i;
    chk("regfile", rf[k], mregs[k]);
  endtask

  // One cycle: inputs already applied; check combinational outputs, step the
  // model at the rising edge, check registered outputs at the falling edge.
  task automatic tick();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("write", write, m_w);
    chk("write_address", write_address, m_wa);
    chk("write_data", write_data, m_wd);
    if (m_w) mregs[m_wa] = m_wd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  logic [4:0] addr_set [5];

  initial begin
    addr_set[0] = 5'd0; addr_set[1] = 5'd1; addr_set[2] = 5'd2;
    addr_set[3] = 5'd3; addr_set[4] = 5'd7;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      mregs[i] = '0;
    end
    reset = 1'b0;
    a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
    a_data = 0; b_data = 0; hz_addr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_write", write, 1'b0);
    chk("rst_write_address", write_address, 5'd0);
    chk("rst_write_data", write_data, 32'd0);
    reset = 1'b1;
    tick();

    // Single A write to register 5.
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF; hz_addr = 5'd5;
    tick();
    a_valid = 0;
    tick();
    chk("single_write", write, 1'b1);
    chk("single_addr", write_address, 5'd5);
    chk("single_data", write_data, 32'hDEADBEEF);
    #1;
    chk("single_rf5", rf[5], 32'hDEADBEEF);
    tick();

    // Both requesters streaming: grants alternate A,B,... from reset.
    do_reset();
    a_valid = 1; a_addr = 5'd1; a_data = $urandom;
    b_valid = 1; b_addr = 5'd2; b_data = $urandom;
    hz_addr = 5'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (acc_a) a_data = $urandom;
      if (acc_b) b_data = $urandom;
`ifndef REG_ARB_FIXED_PRIO_EN
      if (k >= 2) chk("alt_addr", write_address, (k % 2 == 0) ? 5'd1 : 5'd2);
`endif
    end
    a_valid = 0; b_valid = 0;
    tick(); tick();

    // Same address in both buffers.
    do_reset();
    a_valid = 1; a_addr = 5'd7; a_data = 32'h11;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h22;
    tick();
    a_valid = 0; b_valid = 0; hz_addr = 5'd7;
    #1;
    chk("same_hz_pending", hz_pending, 1'b1);
    chk("same_hz_data", hz_data, 32'h22);
    tick();
    chk("same_first", write_data, 32'h11);
    tick();
    chk("same_second", write_data, 32'h22);
    #1;
    chk("same_rf7", rf[7], 32'h22);
    tick();

    // Address 0 write from B is drained without a register-file access.
    b_valid = 1; b_addr = 5'd0; b_data = 32'hFFFF; hz_addr = 5'd0;
    tick();
    b_valid = 0;
    tick();
    chk("zero_write", write, 1'b0);
    #1;
    chk("zero_rf0", rf[0], 32'd0);
    chk("zero_drained_pend", hz_pending, 1'b0);
    tick();

    // Reset between rising edges with both buffers full.
    a_valid = 1; a_addr = 5'd3; a_data = 32'hA5A5_0003;
    b_valid = 1; b_addr = 5'd4; b_data = 32'h5A5A_0004;
    hz_addr = 5'd4;
    repeat (3) tick();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_write", write, 1'b0);
    chk("midrst_a_ready", a_ready, 1'b1);
    chk("midrst_b_ready", b_ready, 1'b1);
    chk("midrst_hz", hz_pending, 1'b0);
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Random traffic honouring the requester hold rule.
    a_valid = 0; b_valid = 0;
    for (int c = 0; c < 400; c++) begin
      if (!(a_valid && !acc_a)) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = addr_set[$urandom_range(0, 4)];
        a_data  = $urandom;
      end
      if (!(b_valid && !acc_b)) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_addr  = addr_set[$urandom_range(0, 4)];
        b_data  = $urandom;
      end
      hz_addr = addr_set[$urandom_range(0, 4)];
      acc_a = 0; acc_b = 0;
      tick();
    end
    a_valid = 0; b_valid = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
